// File: rtl/csr_serializer_pkg.sv
// Shared core package for the CSR serializer.
// Holds the active-list/CSR width constants, the CSR_* address constants, the serializer FSM
// state enum, and the list of counter CSRs that may skip serialization when the
// CSR_READ_BYPASS_EN macro is defined.
package csr_serializer_pkg;

  localparam int unsigned SIZE_ACTIVELIST_LOG = 6;
  localparam int unsigned CSR_WIDTH_LOG       = 12;
  localparam int unsigned CSR_WIDTH           = 32;

  localparam logic [CSR_WIDTH_LOG-1:0] CSR_FFLAGS  = 12'h001;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_FRM     = 12'h002;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_FCSR    = 12'h003;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_CYCLE   = 12'hC00;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_TIME    = 12'hC01;
  localparam logic [CSR_WIDTH_LOG-1:0] CSR_INSTRET = 12'hC02;

  typedef enum logic [1:0] {
    StIdle,
    StWaitHead,
    StExec,
    StWaitCommit
  } csr_ser_state_e;

  // Read-only counters with no side effects; safe to execute out of order.
  localparam int unsigned NumBypassAddr = 3;
  localparam logic [NumBypassAddr-1:0][CSR_WIDTH_LOG-1:0] BypassAddrs =
      {CSR_INSTRET, CSR_TIME, CSR_CYCLE};

  function automatic logic is_bypass_addr(input logic [CSR_WIDTH_LOG-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(NumBypassAddr); i++) begin
      if (addr == BypassAddrs[i]) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/csr_serializer.sv
// CSR serializer for the control lane.
// Holds one CSR op at a time: waits until it reaches the active-list head, lets the control ALU
// execute it, buffers the ALU's CSR write, and performs that write only when the op commits.
// Flush discards the held op; reset aborts it. Dispatch is stalled while an op is in flight.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   flush_i                      pipeline recovery, discards the held op
//   csrReqValid_i/csrReqReady_o  CSR op offer / acceptance (ready only in idle)
//   csrReqAlId_i, csrReqAddr_i   op active-list ID and fn12 CSR address
//   alHeadId_i                   current active-list head ID
//   aluGo_o, aluDone_i           execute permission pulse / ALU executed flag
//   aluCsrWr*_i                  ALU CSR write enable, address, data
//   commitValid_i, commitAlId_i  retiring instruction
//   csrWr*_o                     registered CSR file write port (addr/data zero when idle)
//   dispatchStall_o              holds dispatch while an op is in flight
//
// Macro CSR_READ_BYPASS_EN: counter reads (CYCLE/TIME/INSTRET) requested in idle get aluGo_o
// combinationally and never leave idle or stall dispatch.
module csr_serializer
  import csr_serializer_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush_i,
  input  logic                           csrReqValid_i,
  output logic                           csrReqReady_o,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] csrReqAlId_i,
  input  logic [CSR_WIDTH_LOG-1:0]       csrReqAddr_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] alHeadId_i,
  output logic                           aluGo_o,
  input  logic                           aluDone_i,
  input  logic                           aluCsrWrEn_i,
  input  logic [CSR_WIDTH_LOG-1:0]       aluCsrWrAddr_i,
  input  logic [CSR_WIDTH-1:0]           aluCsrWrData_i,
  input  logic                           commitValid_i,
  input  logic [SIZE_ACTIVELIST_LOG-1:0] commitAlId_i,
  output logic                           csrWrEn_o,
  output logic [CSR_WIDTH_LOG-1:0]       csrWrAddr_o,
  output logic [CSR_WIDTH-1:0]           csrWrData_o,
  output logic                           dispatchStall_o
);

  csr_ser_state_e                 state_q, state_d;
  logic [SIZE_ACTIVELIST_LOG-1:0] held_id_q, held_id_d;
  logic [CSR_WIDTH_LOG-1:0]       held_addr_q, held_addr_d;
  logic                           buf_en_q, buf_en_d;
  logic [CSR_WIDTH_LOG-1:0]       buf_addr_q, buf_addr_d;
  logic [CSR_WIDTH-1:0]           buf_data_q, buf_data_d;
  logic                           alu_go_q, alu_go_d;
  logic                           wr_en_q, wr_en_d;
  logic [CSR_WIDTH_LOG-1:0]       wr_addr_q, wr_addr_d;
  logic [CSR_WIDTH-1:0]           wr_data_q, wr_data_d;
  logic                           bypass_hit;
  logic                           commit_match;

`ifdef CSR_READ_BYPASS_EN
  assign bypass_hit = (state_q == StIdle) && csrReqValid_i && !flush_i &&
                      is_bypass_addr(csrReqAddr_i);
`else
  assign bypass_hit = 1'b0;
`endif

  assign commit_match = commitValid_i && (commitAlId_i == held_id_q);

  // The captured request address is kept with the op for debug visibility only.
  logic unused_held_addr;
  assign unused_held_addr = ^held_addr_q;

  always_comb begin
    state_d     = state_q;
    held_id_d   = held_id_q;
    held_addr_d = held_addr_q;
    buf_en_d    = buf_en_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    alu_go_d    = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = '0;
    wr_data_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (csrReqValid_i && !flush_i && !bypass_hit) begin
          held_id_d   = csrReqAlId_i;
          held_addr_d = csrReqAddr_i;
          state_d     = StWaitHead;
        end
      end
      StWaitHead: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (alHeadId_i == held_id_q) begin
          state_d  = StExec;
          alu_go_d = 1'b1;
        end
      end
      StExec: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (aluDone_i) begin
          buf_en_d   = aluCsrWrEn_i;
          buf_addr_d = aluCsrWrAddr_i;
          buf_data_d = aluCsrWrData_i;
          state_d    = StWaitCommit;
        end
      end
      StWaitCommit: begin
        // A matching commit takes priority over a simultaneous flush.
        if (commit_match) begin
          wr_en_d   = buf_en_q;
          wr_addr_d = buf_en_q ? buf_addr_q : '0;
          wr_data_d = buf_en_q ? buf_data_q : '0;
          state_d   = StIdle;
        end else if (flush_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Leaving an op for any reason drops its buffered write.
    if (state_d == StIdle && state_q != StIdle) begin
      held_id_d   = '0;
      held_addr_d = '0;
      buf_en_d    = 1'b0;
      buf_addr_d  = '0;
      buf_data_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      held_id_q   <= '0;
      held_addr_q <= '0;
      buf_en_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      alu_go_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      held_id_q   <= held_id_d;
      held_addr_q <= held_addr_d;
      buf_en_q    <= buf_en_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      alu_go_q    <= alu_go_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign csrReqReady_o   = (state_q == StIdle);
  assign dispatchStall_o = (state_q != StIdle);
  assign aluGo_o         = alu_go_q | bypass_hit;
  assign csrWrEn_o       = wr_en_q;
  assign csrWrAddr_o     = wr_addr_q;
  assign csrWrData_o     = wr_data_q;

endmodule

// File: tb/tb_csr_serializer.sv
// Self-checking bench for csr_serializer. Expected CSR writes are queued when the committing
// stimulus is driven; a negedge monitor pops and compares them when csrWrEn_o is seen, and flags
// any write nobody expected. Build with +define+CSR_READ_BYPASS_EN to exercise the bypass.
module tb_csr_serializer;
  import csr_serializer_pkg::*;

  logic                           clk;
  logic                           reset_n;
  logic                           flush_i;
  logic                           csrReqValid_i;
  logic                           csrReqReady_o;
  logic [SIZE_ACTIVELIST_LOG-1:0] csrReqAlId_i;
  logic [CSR_WIDTH_LOG-1:0]       csrReqAddr_i;
  logic [SIZE_ACTIVELIST_LOG-1:0] alHeadId_i;
  logic                           aluGo_o;
  logic                           aluDone_i;
  logic                           aluCsrWrEn_i;
  logic [CSR_WIDTH_LOG-1:0]       aluCsrWrAddr_i;
  logic [CSR_WIDTH-1:0]           aluCsrWrData_i;
  logic                           commitValid_i;
  logic [SIZE_ACTIVELIST_LOG-1:0] commitAlId_i;
  logic                           csrWrEn_o;
  logic [CSR_WIDTH_LOG-1:0]       csrWrAddr_o;
  logic [CSR_WIDTH-1:0]           csrWrData_o;
  logic                           dispatchStall_o;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;
  logic [CSR_WIDTH_LOG+CSR_WIDTH-1:0] exp_q[$];

  csr_serializer u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush_i         (flush_i),
    .csrReqValid_i   (csrReqValid_i),
    .csrReqReady_o   (csrReqReady_o),
    .csrReqAlId_i    (csrReqAlId_i),
    .csrReqAddr_i    (csrReqAddr_i),
    .alHeadId_i      (alHeadId_i),
    .aluGo_o         (aluGo_o),
    .aluDone_i       (aluDone_i),
    .aluCsrWrEn_i    (aluCsrWrEn_i),
    .aluCsrWrAddr_i  (aluCsrWrAddr_i),
    .aluCsrWrData_i  (aluCsrWrData_i),
    .commitValid_i   (commitValid_i),
    .commitAlId_i    (commitAlId_i),
    .csrWrEn_o       (csrWrEn_o),
    .csrWrAddr_o     (csrWrAddr_o),
    .csrWrData_o     (csrWrData_o),
    .dispatchStall_o (dispatchStall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every cycle either a queued write or an all-zero idle port.
  always @(negedge clk) begin
    if (mon_en) begin
      if (csrWrEn_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'(csrWrEn_o), 64'd0);
        end else begin
          logic [CSR_WIDTH_LOG+CSR_WIDTH-1:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(csrWrAddr_o), 64'(e[CSR_WIDTH+:CSR_WIDTH_LOG]));
          check("wr_data", 64'(csrWrData_o), 64'(e[CSR_WIDTH-1:0]));
        end
      end else begin
        check("wr_idle_zero", 64'({csrWrEn_o, csrWrAddr_o, csrWrData_o}), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(csrWrEn_o), 64'd0);
    check({tag, "_wr_addr"}, 64'(csrWrAddr_o), 64'd0);
    check({tag, "_wr_data"}, 64'(csrWrData_o), 64'd0);
    check({tag, "_alu_go"}, 64'(aluGo_o), 64'd0);
    check({tag, "_stall"}, 64'(dispatchStall_o), 64'd0);
    check({tag, "_ready"}, 64'(csrReqReady_o), 64'd1);
  endtask

  task automatic request(input logic [SIZE_ACTIVELIST_LOG-1:0] id,
                         input logic [CSR_WIDTH_LOG-1:0] addr);
    csrReqValid_i = 1'b1;
    csrReqAlId_i  = id;
    csrReqAddr_i  = addr;
    check("req_ready", 64'(csrReqReady_o), 64'd1);
    tick();
    csrReqValid_i = 1'b0;
    check("req_stall", 64'(dispatchStall_o), 64'd1);
    check("req_not_ready", 64'(csrReqReady_o), 64'd0);
  endtask

  task automatic to_exec(input logic [SIZE_ACTIVELIST_LOG-1:0] id);
    alHeadId_i = id;
    tick();
    check("go_pulse", 64'(aluGo_o), 64'd1);
  endtask

  task automatic alu_done(input logic en, input logic [CSR_WIDTH_LOG-1:0] addr,
                          input logic [CSR_WIDTH-1:0] data);
    aluDone_i      = 1'b1;
    aluCsrWrEn_i   = en;
    aluCsrWrAddr_i = addr;
    aluCsrWrData_i = data;
    tick();
    aluDone_i      = 1'b0;
    aluCsrWrEn_i   = 1'b0;
    aluCsrWrAddr_i = '0;
    aluCsrWrData_i = '0;
    check("go_one_cycle", 64'(aluGo_o), 64'd0);
    check("wait_commit_stall", 64'(dispatchStall_o), 64'd1);
  endtask

  task automatic commit(input logic [SIZE_ACTIVELIST_LOG-1:0] id, input logic flush,
                        input logic expect_wr, input logic [CSR_WIDTH_LOG-1:0] addr,
                        input logic [CSR_WIDTH-1:0] data);
    commitValid_i = 1'b1;
    commitAlId_i  = id;
    flush_i       = flush;
    if (expect_wr) exp_q.push_back({addr, data});
    tick();
    commitValid_i = 1'b0;
    flush_i       = 1'b0;
    check("commit_idle_stall", 64'(dispatchStall_o), 64'd0);
    check("commit_idle_ready", 64'(csrReqReady_o), 64'd1);
    tick();
    check("wr_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    flush_i        = 1'b0;
    csrReqValid_i  = 1'b0;
    csrReqAlId_i   = '0;
    csrReqAddr_i   = '0;
    alHeadId_i     = '0;
    aluDone_i      = 1'b0;
    aluCsrWrEn_i   = 1'b0;
    aluCsrWrAddr_i = '0;
    aluCsrWrData_i = '0;
    commitValid_i  = 1'b0;
    commitAlId_i   = '0;
    tick();
    tick();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    mon_en  = 1'b1;
    tick();

    // Basic op: head matches right away, done with go, write on commit.
    request(6'd5, CSR_FFLAGS);
    to_exec(6'd5);
    alu_done(1'b1, CSR_FFLAGS, 32'h1F);
    commit(6'd5, 1'b0, 1'b1, CSR_FFLAGS, 32'h1F);

    // Head stuck elsewhere: stall holds, no go, a second offer is not accepted.
    alHeadId_i = 6'd7;
    request(6'd9, CSR_FCSR);
    for (int i = 0; i < 10; i++) begin
      csrReqValid_i = 1'b1;
      csrReqAlId_i  = 6'd40;
      csrReqAddr_i  = CSR_FRM;
      tick();
      check("head_wait_stall", 64'(dispatchStall_o), 64'd1);
      check("head_wait_go", 64'(aluGo_o), 64'd0);
      check("head_wait_ready", 64'(csrReqReady_o), 64'd0);
    end
    csrReqValid_i = 1'b0;
    to_exec(6'd9);
    // Done a cycle after go, read-only: commits with no write.
    tick();
    check("exec_hold_go", 64'(aluGo_o), 64'd0);
    alu_done(1'b0, CSR_FCSR, 32'h55);
    commit(6'd9, 1'b0, 1'b0, '0, '0);

    // Flush while waiting for commit: back to idle, a late commit writes nothing.
    request(6'd3, CSR_FCSR);
    to_exec(6'd3);
    alu_done(1'b1, CSR_FCSR, 32'hAA);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_idle_stall", 64'(dispatchStall_o), 64'd0);
    check("flush_idle_ready", 64'(csrReqReady_o), 64'd1);
    commit(6'd3, 1'b0, 1'b0, '0, '0);

    // Flush while waiting for head.
    alHeadId_i = 6'd1;
    request(6'd50, CSR_FFLAGS);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_head_stall", 64'(dispatchStall_o), 64'd0);

    // Non-matching commit holds; matching commit with flush still writes.
    request(6'd12, CSR_FFLAGS);
    to_exec(6'd12);
    alu_done(1'b1, CSR_FCSR, 32'hDEADBEEF);
    commitValid_i = 1'b1;
    commitAlId_i  = 6'd13;
    tick();
    commitValid_i = 1'b0;
    check("commit_mismatch_hold", 64'(dispatchStall_o), 64'd1);
    commit(6'd12, 1'b1, 1'b1, CSR_FCSR, 32'hDEADBEEF);

    // Wrap-around ID at the top of the active list.
    alHeadId_i = 6'd0;
    request(6'd63, CSR_FRM);
    to_exec(6'd63);
    alu_done(1'b1, CSR_FRM, 32'h7);
    commit(6'd63, 1'b0, 1'b1, CSR_FRM, 32'h7);

    // Reset during execute aborts the op with no write afterwards.
    request(6'd20, CSR_FRM);
    to_exec(6'd20);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("mid_rst");
    reset_n        = 1'b1;
    aluDone_i      = 1'b1;
    aluCsrWrEn_i   = 1'b1;
    aluCsrWrAddr_i = CSR_FRM;
    aluCsrWrData_i = 32'h3;
    commitValid_i  = 1'b1;
    commitAlId_i   = 6'd20;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_stall", 64'(dispatchStall_o), 64'd0);
    end
    aluDone_i      = 1'b0;
    aluCsrWrEn_i   = 1'b0;
    aluCsrWrAddr_i = '0;
    aluCsrWrData_i = '0;
    commitValid_i  = 1'b0;
    tick();

    // Counter read: bypassed in idle, or fully serialized.
    alHeadId_i    = 6'd2;
    csrReqValid_i = 1'b1;
    csrReqAlId_i  = 6'd30;
    csrReqAddr_i  = CSR_CYCLE;
`ifdef CSR_READ_BYPASS_EN
    check("bypass_go", 64'(aluGo_o), 64'd1);
    check("bypass_no_stall", 64'(dispatchStall_o), 64'd0);
    tick();
    csrReqValid_i = 1'b0;
    check("bypass_stay_idle", 64'(dispatchStall_o), 64'd0);
    check("bypass_ready", 64'(csrReqReady_o), 64'd1);
    check("bypass_go_drop", 64'(aluGo_o), 64'd0);
`else
    check("serial_no_early_go", 64'(aluGo_o), 64'd0);
    check("serial_ready", 64'(csrReqReady_o), 64'd1);
    tick();
    csrReqValid_i = 1'b0;
    check("serial_stall", 64'(dispatchStall_o), 64'd1);
    to_exec(6'd30);
    alu_done(1'b0, CSR_CYCLE, 32'h0);
    commit(6'd30, 1'b0, 1'b0, '0, '0);
`endif
    tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_serializer.md
CSR_SERIALIZER -- requirements
Module: csr_serializer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset; reset is synchronous and active-low.
REQ-003 SHALL have port flush_i, input, 1, pipeline recovery (mispredict/exception); discards the held op.
REQ-004 SHALL have ports csrReqValid_i (input, 1) and csrReqReady_o (output, 1): a CSR op is offered to the control lane.
REQ-005 SHALL have ports csrReqAlId_i (input, SIZE_ACTIVELIST_LOG), the op's active-list ID, and csrReqAddr_i (input, CSR_WIDTH_LOG), its fn12 CSR address.
REQ-006 SHALL have port alHeadId_i, input, SIZE_ACTIVELIST_LOG, the current active-list head ID.
REQ-007 SHALL have ports aluGo_o (output, 1), permission for the control ALU to execute the held op, and aluDone_i (input, 1), the ALU's executed flag for it.
REQ-008 SHALL have ALU CSR write inputs: aluCsrWrEn_i (1), aluCsrWrAddr_i (CSR_WIDTH_LOG) and aluCsrWrData_i (CSR_WIDTH).
REQ-009 SHALL have ports commitValid_i (input, 1) and commitAlId_i (input, SIZE_ACTIVELIST_LOG), the retiring instruction.
REQ-010 SHALL have outputs csrWrEn_o (1), csrWrAddr_o (CSR_WIDTH_LOG) and csrWrData_o (CSR_WIDTH), all registered, driving the CSR file.
REQ-011 SHALL have port dispatchStall_o, output, 1, which holds dispatch while a CSR op is in flight.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, WAIT_HEAD, EXEC, WAIT_COMMIT.
REQ-013 IDLE:
- csrReqReady_o=1.
- On csrReqValid_i with flush_i=0: capture ID and address, go to WAIT_HEAD next cycle.
REQ-014 In every non-IDLE state: csrReqReady_o=0 and dispatchStall_o=1; requests offered there are neither accepted nor lost (the requester holds them).
REQ-015 WAIT_HEAD: when alHeadId_i equals the held ID, go to EXEC next cycle; otherwise stay, with no timeout.
REQ-016 aluGo_o SHALL be 1 only in the first cycle of EXEC, as a one-cycle registered pulse.
REQ-017 EXEC:
- aluDone_i is accepted in any EXEC cycle, including the aluGo_o cycle.
- On aluDone_i: latch aluCsrWrEn_i, aluCsrWrAddr_i and aluCsrWrData_i into the write buffer, then go to WAIT_COMMIT.
REQ-018 WAIT_COMMIT: on commitValid_i with commitAlId_i equal to the held ID:
- If the buffered enable is 1: assert csrWrEn_o for exactly one cycle on the next cycle, with the buffered address and data.
- Go to IDLE.
REQ-019 An op with buffered enable 0 (read-only access) SHALL commit with no write.
REQ-020 flush_i in any non-IDLE state SHALL return the FSM to IDLE next cycle and clear the buffer, with no write.
REQ-021 If flush_i and a matching commit occur in the same cycle, the commit SHALL win: the write is performed, then IDLE.
REQ-022 ID comparisons SHALL be exact equality on SIZE_ACTIVELIST_LOG bits; active-list wrap-around needs no special handling.
REQ-023 csrWrAddr_o and csrWrData_o SHALL be 0 whenever csrWrEn_o=0.

Reset
REQ-024 While reset_n=0 at a clock edge, the block SHALL enter IDLE and clear the buffer.
REQ-025 Reset outputs: csrWrEn_o=0, csrWrAddr_o=0, csrWrData_o=0, aluGo_o=0, dispatchStall_o=0, csrReqReady_o=1.
REQ-026 Reset asserted mid-operation SHALL abort the op with no CSR write.

Configuration
REQ-027 Macro CSR_READ_BYPASS_EN, when defined: a request in IDLE whose csrReqAddr_i is CSR_CYCLE, CSR_TIME or CSR_INSTRET SHALL:
- get aluGo_o=1 combinationally in the same cycle;
- not leave IDLE;
- not assert dispatchStall_o.
REQ-028 With CSR_READ_BYPASS_EN undefined, those addresses SHALL be serialized like all other CSR ops.

Structure
REQ-029 The FSM state enum and the bypass-address list SHALL live in the shared core package, alongside the CSR_* address constants.
REQ-030 The block SHALL be a single module with no sub-module.

Verification
REQ-031 Bench SHALL cover: request ID 5, head=5 at the next cycle, aluDone_i with aluGo_o, enable=1, addr FFLAGS, data 0x1F; commit ID 5 -> csrWrEn_o one cycle with addr FFLAGS and data 0x1F, then IDLE.
REQ-032 Bench SHALL cover: request ID 9, head stays at 7 for 10 cycles -> dispatchStall_o=1 throughout, aluGo_o=0, csrReqReady_o=0.
REQ-033 Bench SHALL cover: flush_i in WAIT_COMMIT -> IDLE next cycle, csrWrEn_o never asserted.
REQ-034 Bench SHALL cover: flush_i and a matching commit in the same cycle -> the write occurs.
REQ-035 Bench SHALL cover: reset_n=0 during EXEC -> all outputs at their reset values next cycle; no write after reset_n=1.
REQ-036 Bench SHALL cover: request to CSR_CYCLE -> aluGo_o in the same cycle and no stall with CSR_READ_BYPASS_EN defined; full FSM sequence without it.
